mem_ctrl: RTL and testbench
===========================

// Module: mem_ctrl
// PURPOSE
//  Parametrised single-port synchronous RAM with a req/ack handshake, per-byte write
//  mask, address range checking and an optional zero-fill sweep after reset.
//  Next generation of the fixed 64x128 mem block. Sits between the core datapath
//  and program/data storage. mode=0 read, mode=1 write, as before.
// PARAMETERS
//  DATA_W          64   data width in bits; must be a multiple of 8
//  ADDR_W          7    address width in bits
//  DEPTH           128  number of words; 1 <= DEPTH <= 2**ADDR_W
//  CLEAR_ON_RESET  1    1: zero every word after reset; 0: contents undefined
// PORTS
//  clk       in   1         clock; all state on posedge
//  reset     in   1         asynchronous reset, active-low (0 = in reset)
//  req       in   1         request valid for this cycle
//  mode      in   1         0 = read, 1 = write
//  addr      in   ADDR_W    word address
//  data_in   in   DATA_W    write data
//  wmask     in   DATA_W/8  byte write enables; bit i covers data_in[8i+7:8i]
//  busy      out  1         clear sweep in progress; requests are not accepted
//  ack       out  1         one-cycle pulse: request completed
//  err       out  1         valid only with ack: address was >= DEPTH
//  data_out  out  DATA_W    read data; valid with ack on a read, held until next read ack
// BEHAVIOUR
//  - Reset (reset=0, asynchronous): ack=0, err=0, data_out=0, clear counter=0.
//    busy=1 if CLEAR_ON_RESET, else 0. The RAM array has no reset.
//  - FSM states: CLEAR and IDLE.
//    - Reset release goes to CLEAR if CLEAR_ON_RESET, else to IDLE.
//    - CLEAR: write 0 to word[cnt] each cycle, then cnt++. After the write to
//      cnt == DEPTH-1, go to IDLE.
//    - The sweep takes exactly DEPTH cycles. busy drops on the edge that enters IDLE.
//  - In CLEAR, req is ignored: no ack, no access, and the request is not queued.
//  - Acceptance: req=1 in IDLE is accepted at that posedge.
//    - ack=1 in the following cycle only; latency 1, throughput 1 per cycle.
//    - Back-to-back requests are legal.
//  - Write (mode=1), addr < DEPTH: at the accept edge, update only the bytes whose
//    wmask bit is 1. Other bytes are unchanged. wmask=0 still acks. data_out is unchanged.
//  - Read (mode=0), addr < DEPTH: at the accept edge, data_out <= word[addr].
//  - Write then read of the same addr in consecutive cycles returns the new data.
//    This is inherent, because the write completes at the earlier edge.
//  - Out of range (addr >= DEPTH): ack=1 and err=1. No RAM write.
//    A read drives data_out to 0.
//  - err=0 whenever ack=0.
//  - Reset asserted mid-sweep or mid-request:
//    - Outputs return to reset values at once. An in-flight ack is dropped.
//    - The sweep restarts from word 0 after release.
//    - A write accepted on an edge before reset stays committed.
//  - Counter is ADDR_W+1 bits internally, so DEPTH == 2**ADDR_W terminates without
//    wrap issues.
// TESTING
//  1. Defaults, release reset -> busy=1 for 128 cycles.
//     req with mode=1 during that window -> ack stays 0.
//     Afterwards every address reads 0.
//  2. Write 64'h0000_0000_00ab_cdef to addr 32 with wmask=8'hff, then read addr 32.
//     -> ack 1 cycle after each req; data_out=64'h0000_0000_00ab_cdef.
//  3. Addr 33 cleared; write 64'hffff_ffff_ffff_ffff with wmask=8'h81, then read
//     -> data_out=64'hff00_0000_0000_00ff.
//  4. DEPTH=100: write addr 110, then read addr 110.
//     -> both ack=1 with err=1; data_out=0.
//     Reading addr 99 afterwards -> err=0.
//  5. Pull reset low at sweep cycle 50 for 3 cycles.
//     -> busy/ack/err/data_out=0 immediately.
//     After release, busy=1 for a full 128 cycles.
//  6. Consecutive cycles: write 64'h1234 to addr 5, read addr 5, write 64'h5678 to
//     addr 5, read addr 5.
//     -> acks on 4 consecutive cycles; reads return 64'h1234, then 64'h5678.

Source files
------------

// File: rtl/mem_ctrl_if.sv
// Request/response bus between the core datapath and mem_ctrl.
interface mem_ctrl_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 7
);
    logic                  req;
    logic                  mode;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     data_in;
    logic [DATA_W/8-1:0]   wmask;
    logic                  busy;
    logic                  ack;
    logic                  err;
    logic [DATA_W-1:0]     data_out;

    modport master (
        output req, mode, addr, data_in, wmask,
        input  busy, ack, err, data_out
    );

    modport slave (
        input  req, mode, addr, data_in, wmask,
        output busy, ack, err, data_out
    );
endinterface

// File: rtl/mem_ctrl.sv
// Single-port synchronous RAM with req/ack handshake, byte write mask,
// address range check and optional zero-fill sweep after reset.
module mem_ctrl #(
    parameter int DATA_W         = 64,
    parameter int ADDR_W         = 7,
    parameter int DEPTH          = 128,
    parameter int CLEAR_ON_RESET = 1
) (
    input logic       clk,
    input logic       reset,
    mem_ctrl_if.slave bus
);
    localparam int              BYTES   = DATA_W / 8;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_C  = (ADDR_W + 1)'(DEPTH - 1);

    typedef enum logic {
        CLEAR,
        IDLE
    } state_t;

    localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;

    state_t              state_q, state_d;
    logic [ADDR_W:0]     cnt_q, cnt_d;
    logic                ack_q, ack_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   data_q, data_d;

    logic [DATA_W-1:0]   mem [DEPTH];
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_idx;
    logic [DATA_W-1:0]   mem_wdata;
    logic [BYTES-1:0]    mem_be;
    logic                in_range;

    assign in_range = ({1'b0, bus.addr} < DEPTH_C);

    // Next-state, response and RAM write-port selection.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        data_d    = data_q;
        mem_we    = 1'b0;
        mem_idx   = bus.addr;
        mem_wdata = bus.data_in;
        mem_be    = bus.wmask;
        case (state_q)
            CLEAR: begin
                mem_we    = 1'b1;
                mem_idx   = cnt_q[ADDR_W-1:0];
                mem_wdata = '0;
                mem_be    = '1;
                cnt_d     = cnt_q + (ADDR_W + 1)'(1);
                if (cnt_q == LAST_C) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (bus.req) begin
                    ack_d = 1'b1;
                    if (!in_range) begin
                        err_d = 1'b1;
                        if (!bus.mode) begin
                            data_d = '0;
                        end
                    end else if (bus.mode) begin
                        mem_we = 1'b1;
                    end else begin
                        data_d = mem[bus.addr];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and response registers, asynchronously reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RESET_STATE;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            data_q  <= data_d;
        end
    end

    // RAM array (no reset); writes are suppressed while reset is held so the
    // sweep does not start touching words before release.
    always_ff @(posedge clk) begin
        if (mem_we && reset) begin
            for (int unsigned i = 0; i < BYTES; i++) begin
                if (mem_be[i]) begin
                    mem[mem_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
                end
            end
        end
    end

    assign bus.busy     = (state_q == CLEAR);
    assign bus.ack      = ack_q;
    assign bus.err      = err_q;
    assign bus.data_out = data_q;
endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: a 128-word instance and a 100-word
// instance sharing clock and reset.
module tb_mem_ctrl;
    logic clk;
    logic reset;

    mem_ctrl_if #(.DATA_W(64), .ADDR_W(7)) ifa ();
    mem_ctrl_if #(.DATA_W(64), .ADDR_W(7)) ifb ();

    mem_ctrl #(.DATA_W(64), .ADDR_W(7), .DEPTH(128), .CLEAR_ON_RESET(1)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa.slave)
    );

    mem_ctrl #(.DATA_W(64), .ADDR_W(7), .DEPTH(100), .CLEAR_ON_RESET(1)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        b;      // 0: 128-word instance, 1: 100-word instance
        logic        mode;
        logic [6:0]  addr;
        logic [63:0] din;
        logic [7:0]  wm;
        logic        err;
        logic [63:0] dout;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic b, logic mode, logic [6:0] addr, logic [63:0] din,
                                logic [7:0] wm, logic err, logic [63:0] dout);
        vec_t v;
        v.b = b; v.mode = mode; v.addr = addr; v.din = din;
        v.wm = wm; v.err = err; v.dout = dout;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic idle_bus();
        ifa.req = 1'b0; ifa.mode = 1'b0; ifa.addr = '0; ifa.data_in = '0; ifa.wmask = '0;
        ifb.req = 1'b0; ifb.mode = 1'b0; ifb.addr = '0; ifb.data_in = '0; ifb.wmask = '0;
    endtask

    // Releases reset at a falling edge, holds a write request on A through the
    // sweep, and measures how many edges each instance stays busy.
    task automatic run_sweep(input string tag);
        int  na = 0;
        int  nb = 0;
        int  n  = 0;
        bit  ack_seen = 1'b0;
        @(negedge clk);
        reset       = 1'b1;
        ifa.req     = 1'b1;
        ifa.mode    = 1'b1;
        ifa.addr    = 7'd10;
        ifa.data_in = '1;
        ifa.wmask   = '1;
        while ((ifa.busy || ifb.busy) && n < 400) begin
            @(posedge clk);
            #1;
            n++;
            if (ifa.ack) ack_seen = 1'b1;
            if (na == 0 && !ifa.busy) na = n;
            if (nb == 0 && !ifb.busy) nb = n;
        end
        check({tag, " sweep_len_a"}, 64'(na), 64'd128);
        check({tag, " sweep_len_b"}, 64'(nb), 64'd100);
        check({tag, " ack_during_sweep"}, 64'(ack_seen), 64'd0);
        @(negedge clk);
        idle_bus();
    endtask

    task automatic read_a(input string name, input logic [6:0] addr, input logic [63:0] exp);
        @(negedge clk);
        idle_bus();
        ifa.req  = 1'b1;
        ifa.addr = addr;
        @(posedge clk);
        #1;
        check({name, " ack"}, 64'(ifa.ack), 64'd1);
        check({name, " data"}, ifa.data_out, exp);
        @(negedge clk);
        idle_bus();
    endtask

    initial begin
        reset = 1'b0;
        idle_bus();

        // Table: back-to-back requests with hand-computed responses.
        vecs.push_back(mk(0, 1, 7'd32,  64'h0000_0000_00ab_cdef, 8'hff, 0, 64'h0));
        vecs.push_back(mk(0, 0, 7'd32,  64'h0,                   8'h00, 0, 64'h0000_0000_00ab_cdef));
        vecs.push_back(mk(0, 1, 7'd33,  64'hffff_ffff_ffff_ffff, 8'h81, 0, 64'h0000_0000_00ab_cdef));
        vecs.push_back(mk(0, 0, 7'd33,  64'h0,                   8'h00, 0, 64'hff00_0000_0000_00ff));
        vecs.push_back(mk(0, 1, 7'd5,   64'h1234,                8'hff, 0, 64'hff00_0000_0000_00ff));
        vecs.push_back(mk(0, 0, 7'd5,   64'h0,                   8'h00, 0, 64'h1234));
        vecs.push_back(mk(0, 1, 7'd5,   64'h5678,                8'hff, 0, 64'h1234));
        vecs.push_back(mk(0, 0, 7'd5,   64'h0,                   8'h00, 0, 64'h5678));
        vecs.push_back(mk(0, 1, 7'd5,   64'haaaa_aaaa_aaaa_aaaa, 8'h00, 0, 64'h5678));
        vecs.push_back(mk(0, 0, 7'd5,   64'h0,                   8'h00, 0, 64'h5678));
        vecs.push_back(mk(0, 1, 7'd5,   64'h1111_2222_3333_4444, 8'h0c, 0, 64'h5678));
        vecs.push_back(mk(0, 0, 7'd5,   64'h0,                   8'h00, 0, 64'h0000_0000_3333_5678));
        vecs.push_back(mk(0, 0, 7'd127, 64'h0,                   8'h00, 0, 64'h0));
        vecs.push_back(mk(0, 1, 7'd127, 64'hdead_beef_0bad_f00d, 8'hff, 0, 64'h0));
        vecs.push_back(mk(0, 0, 7'd127, 64'h0,                   8'h00, 0, 64'hdead_beef_0bad_f00d));
        vecs.push_back(mk(1, 1, 7'd110, 64'hffff_ffff_ffff_ffff, 8'hff, 1, 64'h0));
        vecs.push_back(mk(1, 0, 7'd110, 64'h0,                   8'h00, 1, 64'h0));
        vecs.push_back(mk(1, 1, 7'd99,  64'h55,                  8'hff, 0, 64'h0));
        vecs.push_back(mk(1, 0, 7'd99,  64'h0,                   8'h00, 0, 64'h55));
        vecs.push_back(mk(1, 1, 7'd100, 64'h77,                  8'hff, 1, 64'h55));
        vecs.push_back(mk(1, 0, 7'd100, 64'h0,                   8'h00, 1, 64'h0));
        vecs.push_back(mk(1, 0, 7'd99,  64'h0,                   8'h00, 0, 64'h55));
        vecs.push_back(mk(1, 1, 7'd127, 64'h99,                  8'hff, 1, 64'h55));
        vecs.push_back(mk(1, 0, 7'd127, 64'h0,                   8'h00, 1, 64'h0));

        // Reset values.
        #2;
        check("rst busy_a", 64'(ifa.busy), 64'd1);
        check("rst ack_a", 64'(ifa.ack), 64'd0);
        check("rst err_a", 64'(ifa.err), 64'd0);
        check("rst data_a", ifa.data_out, 64'h0);
        check("rst busy_b", 64'(ifb.busy), 64'd1);

        run_sweep("init");

        // Every word reads back zero after the sweep.
        for (int a = 0; a < 128; a++) begin
            @(negedge clk);
            ifa.req = 1'b1; ifa.mode = 1'b0; ifa.addr = 7'(a);
            ifb.req = (a < 100); ifb.mode = 1'b0; ifb.addr = 7'(a);
            @(posedge clk);
            #1;
            check($sformatf("zero_a[%0d]", a), {ifa.ack, ifa.err, ifa.data_out}, {1'b1, 1'b0, 64'h0});
            if (a < 100)
                check($sformatf("zero_b[%0d]", a), {ifb.ack, ifb.err, ifb.data_out}, {1'b1, 1'b0, 64'h0});
        end

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            ifa.req = !vecs[i].b; ifb.req = vecs[i].b;
            ifa.mode = vecs[i].mode; ifb.mode = vecs[i].mode;
            ifa.addr = vecs[i].addr; ifb.addr = vecs[i].addr;
            ifa.data_in = vecs[i].din; ifb.data_in = vecs[i].din;
            ifa.wmask = vecs[i].wm; ifb.wmask = vecs[i].wm;
            @(posedge clk);
            #1;
            if (vecs[i].b) begin
                check($sformatf("vec%0d ack", i), 64'(ifb.ack), 64'd1);
                check($sformatf("vec%0d err", i), 64'(ifb.err), 64'(vecs[i].err));
                check($sformatf("vec%0d data", i), ifb.data_out, vecs[i].dout);
            end else begin
                check($sformatf("vec%0d ack", i), 64'(ifa.ack), 64'd1);
                check($sformatf("vec%0d err", i), 64'(ifa.err), 64'(vecs[i].err));
                check($sformatf("vec%0d data", i), ifa.data_out, vecs[i].dout);
            end
        end
        @(negedge clk);
        idle_bus();
        @(posedge clk);
        #1;
        check("idle ack_a", 64'(ifa.ack), 64'd0);
        check("idle err_b", {ifb.ack, ifb.err}, 64'd0);

        // Reset while an ack is in flight: outputs clear at once.
        @(negedge clk);
        ifa.req = 1'b1; ifa.mode = 1'b0; ifa.addr = 7'd127;
        @(posedge clk);
        #1;
        check("inflight ack", 64'(ifa.ack), 64'd1);
        check("inflight data", ifa.data_out, 64'hdead_beef_0bad_f00d);
        #1;
        reset = 1'b0;
        idle_bus();
        #1;
        check("midreq ack", 64'(ifa.ack), 64'd0);
        check("midreq data", ifa.data_out, 64'h0);
        check("midreq busy", 64'(ifa.busy), 64'd1);
        check("midreq data_b", ifb.data_out, 64'h0);
        repeat (3) @(posedge clk);

        // Reset at sweep cycle 50, held for 3 cycles; sweep must restart.
        @(negedge clk);
        reset = 1'b1;
        repeat (50) @(posedge clk);
        #1;
        check("sweep50 busy", 64'(ifa.busy), 64'd1);
        #1;
        reset = 1'b0;
        #1;
        check("midsweep busy", 64'(ifa.busy), 64'd1);
        check("midsweep ack_err", {ifa.ack, ifa.err}, 64'd0);
        check("midsweep data", ifa.data_out, 64'h0);
        repeat (3) @(posedge clk);
        run_sweep("restart");
        read_a("post_restart w127", 7'd127, 64'h0);
        read_a("post_restart w5", 7'd5, 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
